// File: rtl/mkio_tx_sched.sv
// Arbitrates the shared MKIO transmitter between the read-response (req0) and
// write-status (req1) paths. Optional per-word watchdog: define MKIO_TX_WDT_EN.
module mkio_tx_sched #(
  parameter logic [15:0] GAP_CYCLES = 16'd400,
  parameter logic [15:0] BUSY_TO    = 16'd64,
  parameter logic [15:0] WORD_TO    = 16'd2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        abort,
  input  logic        req0_ready,
  input  logic [15:0] req0_data,
  input  logic        req0_cd,
  input  logic        req0_last,
  output logic        req0_ack,
  input  logic        req1_ready,
  input  logic [15:0] req1_data,
  input  logic        req1_cd,
  input  logic        req1_last,
  output logic        req1_ack,
  output logic        tx_ready,
  output logic [15:0] tx_data,
  output logic        tx_cd,
  input  logic        tx_busy,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        err,
  output logic [2:0]  state_dbg
);

  // Handshake: a requester holds reqN_ready with a stable word until it sees
  // reqN_ack for one cycle; that same cycle tx_ready pulses to the transmitter,
  // which answers by raising tx_busy and lowers it when the frame is done.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GAP       = 3'd1,
    LOAD      = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t      state;
  logic [15:0] gap_cnt;
  logic [15:0] to_cnt;
  logic        last_q;
  logic        rr_pri;

  logic        sel_ready;
  logic [15:0] sel_data;
  logic        sel_cd;
  logic        sel_last;

  assign sel_ready = grant[1] ? req1_ready : (grant[0] & req0_ready);
  assign sel_data  = grant[1] ? req1_data  : req0_data;
  assign sel_cd    = grant[1] ? req1_cd    : req0_cd;
  assign sel_last  = grant[1] ? req1_last  : req0_last;
  assign state_dbg = state;

`ifdef MKIO_TX_WDT_EN
  logic [15:0] wd_cnt;
  logic        wd_on;
`else
  logic [15:0] word_to_unused;
  assign word_to_unused = WORD_TO;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gap_cnt  <= 16'd0;
      to_cnt   <= 16'd0;
      last_q   <= 1'b0;
      rr_pri   <= 1'b0;
      grant    <= 2'b00;
      busy     <= 1'b0;
      err      <= 1'b0;
      tx_ready <= 1'b0;
      tx_data  <= 16'h0000;
      tx_cd    <= 1'b0;
      req0_ack <= 1'b0;
      req1_ack <= 1'b0;
`ifdef MKIO_TX_WDT_EN
      wd_cnt   <= 16'd0;
      wd_on    <= 1'b0;
`endif
    end else begin
      tx_ready <= 1'b0;
      req0_ack <= 1'b0;
      req1_ack <= 1'b0;
      err      <= 1'b0;
      if (abort) begin
        state <= IDLE;
        grant <= 2'b00;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (req0_ready || req1_ready) begin
              // Contention goes to rr_pri; a lone requester wins regardless.
              if (req0_ready && (!req1_ready || !rr_pri)) grant <= 2'b01;
              else                                        grant <= 2'b10;
              gap_cnt <= GAP_CYCLES;
              busy    <= 1'b1;
              state   <= (GAP_CYCLES == 16'd0) ? LOAD : GAP;
`ifdef MKIO_TX_WDT_EN
              wd_on   <= 1'b0;
`endif
            end
          end
          GAP: begin
            if (gap_cnt <= 16'd1) begin
              gap_cnt <= 16'd0;
              state   <= LOAD;
            end else begin
              gap_cnt <= gap_cnt - 16'd1;
            end
          end
          LOAD: begin
            if (sel_ready) begin
              tx_data  <= sel_data;
              tx_cd    <= sel_cd;
              last_q   <= sel_last;
              req0_ack <= grant[0];
              req1_ack <= grant[1];
              tx_ready <= 1'b1;
              to_cnt   <= BUSY_TO;
              state    <= WAIT_BUSY;
            end
`ifdef MKIO_TX_WDT_EN
            else if (wd_on) begin
              if (wd_cnt <= 16'd1) begin
                wd_cnt <= 16'd0;
                err    <= 1'b1;
                grant  <= 2'b00;
                busy   <= 1'b0;
                state  <= IDLE;
              end else begin
                wd_cnt <= wd_cnt - 16'd1;
              end
            end
`endif
          end
          WAIT_BUSY: begin
            if (tx_busy) begin
              state <= WAIT_IDLE;
            end else if (to_cnt <= 16'd1) begin
              to_cnt <= 16'd0;
              err    <= 1'b1;
              grant  <= 2'b00;
              busy   <= 1'b0;
              state  <= IDLE;
            end else begin
              to_cnt <= to_cnt - 16'd1;
            end
          end
          WAIT_IDLE: begin
            if (!tx_busy) begin
              if (last_q) begin
                // Priority passes to the requester that did not just finish.
                rr_pri <= grant[0];
                grant  <= 2'b00;
                busy   <= 1'b0;
                state  <= IDLE;
              end else begin
                state  <= LOAD;
`ifdef MKIO_TX_WDT_EN
                wd_cnt <= WORD_TO;
                wd_on  <= 1'b1;
`endif
              end
            end
          end
          default: begin
            state <= IDLE;
            grant <= 2'b00;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
